// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port and mem_responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic        swb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output mem_read, mem_write, swb, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, swb, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then performs
// a word read, word write or byte store on a word array and pulses ready.
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_LOAD = (LATENCY != 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_rd, r_wr, r_swb;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_rd, w_wr, w_swb;
    logic [31:0]       w_addr, w_wdata;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [4:0]        w_lane_lsb;

    always_comb begin
        w_accept    = (r_state == IDLE) && (bus.mem_read || bus.mem_write);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY != 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_enter_resp = (w_state_nxt == RESP);
    end

    // With LATENCY=0 the access happens on the accepting edge, so use the live inputs there.
    always_comb begin
        w_rd    = r_rd;
        w_wr    = r_wr;
        w_swb   = r_swb;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_rd    = bus.mem_read;
            w_wr    = bus.mem_write;
            w_swb   = bus.swb;
            w_addr  = bus.addr;
            w_wdata = bus.wdata;
        end
        w_idx      = w_addr[ADDR_W+1:2];
        w_lane_lsb = {w_addr[1:0], 3'b000};
        w_err      = (w_rd && w_wr)
                  || (|w_addr[31:ADDR_W+2])
                  || (!w_swb && (|w_addr[1:0]))
                  || (w_swb && w_rd);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_swb   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rd    <= bus.mem_read;
                r_wr    <= bus.mem_write;
                r_swb   <= bus.swb;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (w_enter_resp) begin
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= '0;
                end else if (w_rd) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Array is never cleared; a reset on the commit edge drops the pending write.
    always_ff @(posedge clk) begin
        if (reset && w_enter_resp && w_wr && !w_err) begin
            if (w_swb) begin
                r_mem[w_idx][w_lane_lsb +: 8] <= w_wdata[7:0];
            end else begin
                r_mem[w_idx] <= w_wdata;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = (r_state == RESP);
    assign bus.busy  = (r_state != IDLE);
    assign bus.err   = (r_state == RESP) && r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=0 instance checked every cycle
// against a timestamp-based transaction model, plus directed literal expectations.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        rd [2], wr [2], sb [2];
    logic [31:0] ad [2], wd [2];
    logic [31:0] o_rdata [2];
    logic        o_ready [2], o_busy [2], o_err [2];

    mem_responder_if bus_l2 ();
    mem_responder_if bus_l0 ();

    assign bus_l2.mem_read  = rd[0];
    assign bus_l2.mem_write = wr[0];
    assign bus_l2.swb       = sb[0];
    assign bus_l2.addr      = ad[0];
    assign bus_l2.wdata     = wd[0];
    assign o_rdata[0]       = bus_l2.rdata;
    assign o_ready[0]       = bus_l2.ready;
    assign o_busy[0]        = bus_l2.busy;
    assign o_err[0]         = bus_l2.err;

    assign bus_l0.mem_read  = rd[1];
    assign bus_l0.mem_write = wr[1];
    assign bus_l0.swb       = sb[1];
    assign bus_l0.addr      = ad[1];
    assign bus_l0.wdata     = wd[1];
    assign o_rdata[1]       = bus_l0.rdata;
    assign o_ready[1]       = bus_l0.ready;
    assign o_busy[1]        = bus_l0.busy;
    assign o_err[1]         = bus_l0.err;

    mem_responder #(.ADDR_W(8), .LATENCY(2)) dut_l2 (.clk(clk), .reset(rst_n[0]), .bus(bus_l2));
    mem_responder #(.ADDR_W(8), .LATENCY(0)) dut_l0 (.clk(clk), .reset(rst_n[1]), .bus(bus_l0));

    int          n_checks = 0;
    int          n_errors = 0;
    bit          checking = 1'b0;

    // Model: each request gets a response timestamp; outputs follow from timestamps.
    int unsigned ecnt = 0;
    bit          pend [2];
    int unsigned t_resp [2], free_at [2];
    logic        c_rd [2], c_wr [2], c_sb [2];
    logic [31:0] c_ad [2], c_wd [2];
    logic [31:0] mm [2][256];
    logic        e_ready [2], e_busy [2], e_err [2];
    logic [31:0] e_rdata [2];

    function automatic int unsigned lat_of(input int g);
        return (g == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic respond(input int g);
        logic [31:0] a;
        int unsigned sh;
        bit          bad;
        a   = c_ad[g];
        bad = (c_rd[g] && c_wr[g]) || (a > 32'h3FF) || (!c_sb[g] && (a % 4 != 0))
              || (c_sb[g] && c_rd[g]);
        e_err[g] = bad;
        if (bad) begin
            e_rdata[g] = 32'h0;
        end else if (c_rd[g]) begin
            e_rdata[g] = mm[g][a / 4];
        end else if (c_sb[g]) begin
            sh = 8 * (a % 4);
            mm[g][a / 4] = (mm[g][a / 4] & ~(32'hFF << sh)) | ({24'h0, c_wd[g][7:0]} << sh);
        end else begin
            mm[g][a / 4] = c_wd[g];
        end
    endtask

    task automatic model_edge();
        for (int g = 0; g < 2; g++) begin
            if (!rst_n[g]) begin
                pend[g]    = 1'b0;
                free_at[g] = ecnt + 1;
                e_ready[g] = 1'b0;
                e_busy[g]  = 1'b0;
                e_err[g]   = 1'b0;
                e_rdata[g] = 32'h0;
            end else begin
                e_ready[g] = 1'b0;
                e_busy[g]  = 1'b0;
                e_err[g]   = 1'b0;
                if (!pend[g] && ecnt >= free_at[g] && (rd[g] || wr[g])) begin
                    pend[g]   = 1'b1;
                    t_resp[g] = ecnt + lat_of(g);
                    c_rd[g] = rd[g]; c_wr[g] = wr[g]; c_sb[g] = sb[g];
                    c_ad[g] = ad[g]; c_wd[g] = wd[g];
                end
                if (pend[g] && ecnt == t_resp[g]) begin
                    respond(g);
                    e_ready[g] = 1'b1;
                    e_busy[g]  = 1'b1;
                    pend[g]    = 1'b0;
                    free_at[g] = ecnt + 2;
                end else if (pend[g]) begin
                    e_busy[g] = 1'b1;
                end
            end
        end
        ecnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (checking) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("d%0d ready", g), {31'h0, o_ready[g]}, {31'h0, e_ready[g]});
                chk($sformatf("d%0d busy", g),  {31'h0, o_busy[g]},  {31'h0, e_busy[g]});
                chk($sformatf("d%0d err", g),   {31'h0, o_err[g]},   {31'h0, e_err[g]});
                chk($sformatf("d%0d rdata", g), o_rdata[g], e_rdata[g]);
            end
        end
    endtask

    task automatic clear(input int g);
        rd[g] = 1'b0; wr[g] = 1'b0; sb[g] = 1'b0;
    endtask

    task automatic txn(input int g, input logic r, input logic w, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       output logic [31:0] q, output logic e);
        int n;
        rd[g] = r; wr[g] = w; sb[g] = s; ad[g] = a; wd[g] = d;
        step();
        clear(g);
        n = 0;
        while (o_ready[g] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("d%0d latency @%h", g, a), n, exp_lat);
        q = o_rdata[g];
        e = o_err[g];
        if (o_ready[g] === 1'b1) step();
    endtask

    initial begin
        logic [31:0] q;
        logic        e;
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0;
            clear(g);
            ad[g] = 32'h0;
            wd[g] = 32'h0;
            for (int i = 0; i < 256; i++) mm[g][i] = 32'h0;
        end
        step();
        checking = 1'b1;
        step();
        chk("reset ready", {31'h0, o_ready[0]}, 32'h0);
        chk("reset busy",  {31'h0, o_busy[0]},  32'h0);
        chk("reset rdata", o_rdata[0], 32'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        // word write then read back
        txn(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2, q, e);
        chk("wr err", {31'h0, e}, 32'h0);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("rd 0x10", q, 32'hDEADBEEF);
        chk("rd err", {31'h0, e}, 32'h0);

        // byte stores into lanes 1 and 3
        txn(0, 1'b0, 1'b1, 1'b1, 32'h11, 32'hFFFFFF5A, 2, q, e);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("byte lane1", q, 32'hDEAD5AEF);
        txn(0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0000005A, 2, q, e);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("byte lane3", q, 32'h5AAD5AEF);
        txn(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 2, q, e);
        chk("wr keeps rdata", q, 32'h5AAD5AEF);

        // rejected requests
        txn(0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0, 2, q, e);
        chk("misaligned err", {31'h0, e}, 32'h1);
        chk("misaligned rdata", q, 32'h0);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 2, q, e);
        chk("range err", {31'h0, e}, 32'h1);
        txn(0, 1'b0, 1'b1, 1'b0, 32'h410, 32'h11111111, 2, q, e);
        chk("range wr err", {31'h0, e}, 32'h1);
        txn(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("rd+wr err", {31'h0, e}, 32'h1);
        txn(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 2, q, e);
        chk("swb read err", {31'h0, e}, 32'h1);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("unchanged after errs", q, 32'h5AAD5AEF);

        // reset during WAIT of a write
        wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h12345678;
        step();
        clear(0);
        chk("abort busy1", {31'h0, o_busy[0]}, 32'h1);
        step();
        rst_n[0] = 1'b0;
        step();
        chk("abort ready", {31'h0, o_ready[0]}, 32'h0);
        chk("abort busy", {31'h0, o_busy[0]}, 32'h0);
        rst_n[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no late ready", {31'h0, o_ready[0]}, 32'h0);
        end
        txn(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 2, q, e);
        chk("old data 0x20", q, 32'hCAFEF00D);

        // inputs change during WAIT
        rd[0] = 1'b1; ad[0] = 32'h10;
        step();
        chk("wait busy a", {31'h0, o_busy[0]}, 32'h1);
        rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 32'h10; wd[0] = 32'hFFFFFFFF;
        step();
        chk("wait busy b", {31'h0, o_busy[0]}, 32'h1);
        step();
        chk("captured ready", {31'h0, o_ready[0]}, 32'h1);
        chk("captured rdata", o_rdata[0], 32'h5AAD5AEF);
        clear(0);
        step();
        chk("idle busy", {31'h0, o_busy[0]}, 32'h0);
        txn(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 2, q, e);
        chk("ignored write", q, 32'h5AAD5AEF);

        // zero-latency instance, back-to-back reads
        txn(1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hA5A50001, 0, q, e);
        txn(1, 1'b0, 1'b1, 1'b0, 32'h4, 32'h5A5A0004, 0, q, e);
        rd[1] = 1'b1; ad[1] = 32'h0;
        step();
        chk("l0 first ready", {31'h0, o_ready[1]}, 32'h1);
        chk("l0 first rdata", o_rdata[1], 32'hA5A50001);
        ad[1] = 32'h4;
        step();
        chk("l0 gap", {31'h0, o_ready[1]}, 32'h0);
        step();
        chk("l0 second ready", {31'h0, o_ready[1]}, 32'h1);
        chk("l0 second rdata", o_rdata[1], 32'h5A5A0004);
        clear(1);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
